// File: rtl/redux_pipe.sv
// Streaming multi-operand adder: extend/negate M operands, reduce them in a 3:2
// carry-save tree registered every S levels, then carry-propagate into the output register.
module redux_pipe #(
  parameter int unsigned W      = 8,
  parameter int unsigned M      = 8,
  parameter int unsigned S      = 2,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned OW     = W + $clog2(M),
  parameter int unsigned TW     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [M*W-1:0]  in_data,
  input  logic [M-1:0]    in_neg,
  input  logic [TW-1:0]   in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OW-1:0]   out_sum,
  output logic [TW-1:0]   out_tag
);

  // M operands plus the popcount(in_neg) correction term
  localparam int unsigned N0 = M + 1;

  function automatic int unsigned ops_at(input int unsigned lvl);
    int unsigned n;
    n = N0;
    for (int unsigned i = 0; i < lvl; i++) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction

  function automatic int unsigned tree_depth(input int unsigned n0);
    int unsigned n;
    int unsigned d;
    n = n0;
    d = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + n % 3;
      d++;
    end
    return d;
  endfunction

  function automatic logic [OW-1:0] carry3(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                           input logic [OW-1:0] c);
    logic [OW-1:0] m;
    m = (a & b) | (a & c) | (b & c);
    return m << 1;
  endfunction

  localparam int unsigned D = tree_depth(N0);

  logic          w_adv;
  logic [OW-1:0] w_sum;

  // One shared enable: everything shifts unless a result is waiting on the consumer
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k <= D; k++) begin : g_lvl
    localparam int unsigned NK = ops_at(k);

    logic [NK*OW-1:0] w_lvl;   // combinational result of level k
    logic             w_v;
    logic [TW-1:0]    w_t;
    logic [NK*OW-1:0] w_srcl;  // level k as seen by level k+1
    logic             w_vs;
    logic [TW-1:0]    w_ts;

    if (k == 0) begin : g_ext
      always_comb begin
        w_lvl = '0;
        for (int unsigned i = 0; i < M; i++) begin
          w_lvl[i*OW +: OW] = {{(OW-W){(SIGNED != 0) && in_data[i*W+W-1]}}, in_data[i*W +: W]}
                              ^ {OW{in_neg[i]}};
        end
        for (int unsigned i = 0; i < M; i++) begin
          w_lvl[M*OW +: OW] = w_lvl[M*OW +: OW] + OW'(in_neg[i]);
        end
      end
      assign w_v = in_valid;
      assign w_t = in_tag;
    end else begin : g_csa
      localparam int unsigned NP = ops_at(k - 1);
      localparam int unsigned G  = NP / 3;

      logic [NP*OW-1:0] w_prev;
      assign w_prev = g_lvl[k-1].w_srcl;

      // Full groups of three compress to sum/carry; leftovers pass straight through
      always_comb begin
        w_lvl = '0;
        for (int unsigned g = 0; g < G; g++) begin
          w_lvl[2*g*OW +: OW]     = w_prev[3*g*OW +: OW] ^ w_prev[(3*g+1)*OW +: OW]
                                    ^ w_prev[(3*g+2)*OW +: OW];
          w_lvl[(2*g+1)*OW +: OW] = carry3(w_prev[3*g*OW +: OW], w_prev[(3*g+1)*OW +: OW],
                                           w_prev[(3*g+2)*OW +: OW]);
        end
        for (int unsigned r = 0; r < NP - 3 * G; r++) begin
          w_lvl[(2*G+r)*OW +: OW] = w_prev[(3*G+r)*OW +: OW];
        end
      end
      assign w_v = g_lvl[k-1].w_vs;
      assign w_t = g_lvl[k-1].w_ts;
    end

    if ((k > 0) && (k < D) && ((k % S) == 0)) begin : g_reg
      logic [NK*OW-1:0] r_lvl;
      logic             r_v;
      logic [TW-1:0]    r_t;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_lvl <= '0;
          r_v   <= 1'b0;
          r_t   <= '0;
        end else if (w_adv) begin
          r_lvl <= w_lvl;
          r_v   <= w_v;
          r_t   <= w_t;
        end
      end
      assign w_srcl = r_lvl;
      assign w_vs   = r_v;
      assign w_ts   = r_t;
    end else begin : g_pass
      assign w_srcl = w_lvl;
      assign w_vs   = w_v;
      assign w_ts   = w_t;
    end
  end

  assign w_sum = g_lvl[D].w_srcl[0 +: OW] + g_lvl[D].w_srcl[OW +: OW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_tag   <= '0;
    end else if (w_adv) begin
      out_valid <= g_lvl[D].w_vs;
      out_sum   <= w_sum;
      out_tag   <= g_lvl[D].w_ts;
    end
  end

endmodule

// File: tb/tb_redux_pipe.sv
// Bench for redux_pipe: vector table and scoreboards over several parameter sets.
module tb_redux_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Group A: W=8 M=8 S=2 unsigned (u) and signed (b) sharing stimulus
  logic        a_valid, a_irdy, b_irdy, a_ordy;
  logic [63:0] a_data;
  logic [7:0]  a_neg;
  logic [3:0]  a_tag, a_otag, b_otag;
  logic        a_ov, b_ov;
  logic [10:0] a_osum, b_osum;

  redux_pipe #(.W(8), .M(8), .S(2), .SIGNED(0), .OW(11), .TW(4)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_irdy), .in_data(a_data),
    .in_neg(a_neg), .in_tag(a_tag), .out_valid(a_ov), .out_ready(a_ordy), .out_sum(a_osum),
    .out_tag(a_otag));

  redux_pipe #(.W(8), .M(8), .S(2), .SIGNED(1), .OW(11), .TW(4)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(b_irdy), .in_data(a_data),
    .in_neg(a_neg), .in_tag(a_tag), .out_valid(b_ov), .out_ready(a_ordy), .out_sum(b_osum),
    .out_tag(b_otag));

  // Group C: small corner configurations
  logic        c2_valid, c2_irdy, c2_ov;
  logic [15:0] c2_data;
  logic [1:0]  c2_neg;
  logic [3:0]  c2_tag, c2_otag;
  logic [8:0]  c2_osum;
  logic        c3_valid, c3_irdy, c3_ov;
  logic [23:0] c3_data;
  logic [2:0]  c3_neg;
  logic [3:0]  c3_tag, c3_otag;
  logic [9:0]  c3_osum;

  redux_pipe #(.W(8), .M(2), .S(1), .SIGNED(0), .OW(9), .TW(4)) u_dut_m2 (
    .clk(clk), .rst_n(rst_n), .in_valid(c2_valid), .in_ready(c2_irdy), .in_data(c2_data),
    .in_neg(c2_neg), .in_tag(c2_tag), .out_valid(c2_ov), .out_ready(1'b1), .out_sum(c2_osum),
    .out_tag(c2_otag));

  redux_pipe #(.W(8), .M(3), .S(1), .SIGNED(0), .OW(10), .TW(4)) u_dut_m3 (
    .clk(clk), .rst_n(rst_n), .in_valid(c3_valid), .in_ready(c3_irdy), .in_data(c3_data),
    .in_neg(c3_neg), .in_tag(c3_tag), .out_valid(c3_ov), .out_ready(1'b1), .out_sum(c3_osum),
    .out_tag(c3_otag));

  // Group D: W=16 M=5 S=3 signed, randomised traffic
  logic        d_valid, d_irdy, d_ov;
  logic        d_ordy = 1'b1;
  logic        d_rand_on = 1'b0;
  logic [79:0] d_data;
  logic [4:0]  d_neg;
  logic [3:0]  d_tag, d_otag;
  logic [18:0] d_osum;

  redux_pipe #(.W(16), .M(5), .S(3), .SIGNED(1), .OW(19), .TW(4)) u_dut_d (
    .clk(clk), .rst_n(rst_n), .in_valid(d_valid), .in_ready(d_irdy), .in_data(d_data),
    .in_neg(d_neg), .in_tag(d_tag), .out_valid(d_ov), .out_ready(d_ordy), .out_sum(d_osum),
    .out_tag(d_otag));

  typedef struct {
    logic [63:0] data;
    logic [7:0]  neg;
    logic [10:0] exp_u;
    logic [10:0] exp_s;
  } vec_t;
  vec_t tbl [8];

  logic [14:0] qa[$];
  logic [14:0] qb[$];
  logic [22:0] qd[$];
  logic [14:0] ea, eb;
  logic [22:0] ed;

  function automatic logic [18:0] model_d(input logic [79:0] d, input logic [4:0] n);
    logic [18:0] acc;
    logic [15:0] x;
    logic [18:0] e;
    acc = '0;
    for (int i = 0; i < 5; i++) begin
      x   = d[i*16 +: 16];
      e   = {{3{x[15]}}, x};
      acc = n[i] ? acc - e : acc + e;
    end
    return acc;
  endfunction

  // Scoreboards: an output handshake seen here completes on the next rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      qd.delete();
    end else begin
      if (a_ov && a_ordy) begin
        chk("a_out_expected", 32'(qa.size() != 0), 32'd1);
        if (qa.size() != 0) begin
          ea = qa.pop_front();
          chk("a_sum", 32'(a_osum), 32'(ea[10:0]));
          chk("a_tag", 32'(a_otag), 32'(ea[14:11]));
        end
      end
      if (b_ov && a_ordy) begin
        chk("b_out_expected", 32'(qb.size() != 0), 32'd1);
        if (qb.size() != 0) begin
          eb = qb.pop_front();
          chk("b_sum", 32'(b_osum), 32'(eb[10:0]));
          chk("b_tag", 32'(b_otag), 32'(eb[14:11]));
        end
      end
      if (d_ov && d_ordy) begin
        chk("d_out_expected", 32'(qd.size() != 0), 32'd1);
        if (qd.size() != 0) begin
          ed = qd.pop_front();
          chk("d_sum", 32'(d_osum), 32'(ed[18:0]));
          chk("d_tag", 32'(d_otag), 32'(ed[22:19]));
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    d_ordy = d_rand_on ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  task automatic send_a(input int r, input logic [3:0] t);
    int unsigned g;
    g       = 0;
    a_valid = 1'b1;
    a_data  = tbl[r].data;
    a_neg   = tbl[r].neg;
    a_tag   = t;
    @(negedge clk);
    while (!a_irdy && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("a_in_handshake", 32'(a_irdy), 32'd1);
    qa.push_back({t, tbl[r].exp_u});
    qb.push_back({t, tbl[r].exp_s});
    @(posedge clk);
    #1;
    a_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int unsigned g;
    g = 0;
    while ((qa.size() + qb.size() + qd.size()) != 0 && g < 500) begin
      @(posedge clk);
      g++;
    end
    #1;
    chk(nm, 32'(qa.size() + qb.size() + qd.size()), 32'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    tbl[0] = '{64'hFFFFFFFFFFFFFFFF, 8'h00, 11'h7F8, 11'h7F8};
    tbl[1] = '{64'h8080808080808080, 8'h00, 11'h400, 11'h400};
    tbl[2] = '{64'hFC04FD03FE02FF01, 8'h00, 11'h400, 11'h000};
    tbl[3] = '{64'h0000000000000005, 8'h01, 11'h7FB, 11'h7FB};
    tbl[4] = '{64'hFFFFFFFFFFFFFFFF, 8'hFF, 11'h008, 11'h008};
    tbl[5] = '{64'h0706050403020100, 8'h00, 11'h01C, 11'h01C};
    tbl[6] = '{64'h7F7F7F7F7F7F7F7F, 8'hAA, 11'h000, 11'h000};
    tbl[7] = '{64'h0000000000000080, 8'h01, 11'h780, 11'h080};

    rst_n = 1'b0;
    a_valid = 1'b0; a_data = '0; a_neg = '0; a_tag = '0; a_ordy = 1'b1;
    c2_valid = 1'b0; c2_data = '0; c2_neg = '0; c2_tag = '0;
    c3_valid = 1'b0; c3_data = '0; c3_neg = '0; c3_tag = '0;
    d_valid = 1'b0; d_data = '0; d_neg = '0; d_tag = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_out_valid", 32'(a_ov), 32'd0);
    chk("rst_a_out_sum", 32'(a_osum), 32'd0);
    chk("rst_a_out_tag", 32'(a_otag), 32'd0);
    chk("rst_a_in_ready", 32'(a_irdy), 32'd1);
    chk("rst_d_out_valid", 32'(d_ov), 32'd0);
    rst_n = 1'b1;

    for (int r = 0; r < 8; r++) send_a(r, 4'(r));
    drain("table_drain");

    // Latency of the default configuration
    send_a(0, 4'hA);
    chk("lat2_early_valid", 32'(a_ov), 32'd0);
    @(posedge clk);
    #1;
    chk("lat2_valid", 32'(a_ov), 32'd1);
    chk("lat2_sum", 32'(a_osum), 32'h7F8);
    chk("lat2_tag", 32'(a_otag), 32'hA);
    drain("lat_drain");

    // Back-to-back stream with a 3-cycle stall while tag 1 is at the output
    fork
      begin
        for (int i = 0; i < 6; i++) send_a(i, 4'(i));
      end
      begin
        int unsigned g;
        g = 0;
        @(posedge clk);
        #1;
        while (!(a_ov && a_otag == 4'd1) && g < 50) begin
          @(posedge clk);
          #1;
          g++;
        end
        chk("stall_tag1_reached", 32'(g < 50), 32'd1);
        a_ordy = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(a_irdy), 32'd0);
          chk("stall_s_in_ready", 32'(b_irdy), 32'd0);
          chk("stall_hold_sum", 32'(a_osum), 32'(tbl[1].exp_u));
          chk("stall_hold_tag", 32'(a_otag), 32'd1);
        end
        @(posedge clk);
        #1;
        a_ordy = 1'b1;
      end
    join
    drain("stall_drain");

    // Reset with two beats in flight
    send_a(1, 4'h6);
    send_a(2, 4'h7);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(a_ov), 32'd0);
    chk("midrst_s_out_valid", 32'(b_ov), 32'd0);
    chk("midrst_out_sum", 32'(a_osum), 32'd0);
    chk("midrst_in_ready", 32'(a_irdy), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_a(3, 4'h8);
    chk("postrst_early_valid", 32'(a_ov), 32'd0);
    @(posedge clk);
    #1;
    chk("postrst_valid", 32'(a_ov), 32'd1);
    chk("postrst_tag", 32'(a_otag), 32'h8);
    drain("postrst_drain");

    // M=2, S=1: one-cycle latency
    chk("m2_in_ready", 32'(c2_irdy), 32'd1);
    c2_valid = 1'b1; c2_data = {8'h01, 8'h7F}; c2_neg = 2'b00; c2_tag = 4'd1;
    @(posedge clk);
    #1;
    chk("m2_valid", 32'(c2_ov), 32'd1);
    chk("m2_sum", 32'(c2_osum), 32'h080);
    chk("m2_tag", 32'(c2_otag), 32'd1);
    c2_data = {8'h01, 8'h7F}; c2_neg = 2'b10; c2_tag = 4'd2;
    @(posedge clk);
    #1;
    c2_valid = 1'b0;
    chk("m2_neg_sum", 32'(c2_osum), 32'h07E);
    chk("m2_neg_tag", 32'(c2_otag), 32'd2);
    @(posedge clk);
    #1;
    chk("m2_idle_valid", 32'(c2_ov), 32'd0);

    // M=3, S=1: two-cycle latency
    chk("m3_in_ready", 32'(c3_irdy), 32'd1);
    c3_valid = 1'b1; c3_data = {8'hFF, 8'hFF, 8'hFF}; c3_neg = 3'b010; c3_tag = 4'd1;
    @(posedge clk);
    #1;
    c3_data = {8'd10, 8'd20, 8'd30}; c3_neg = 3'b111; c3_tag = 4'd2;
    chk("m3_early_valid", 32'(c3_ov), 32'd0);
    @(posedge clk);
    #1;
    c3_valid = 1'b0;
    chk("m3_valid", 32'(c3_ov), 32'd1);
    chk("m3_sum", 32'(c3_osum), 32'h0FF);
    chk("m3_tag", 32'(c3_otag), 32'd1);
    @(posedge clk);
    #1;
    chk("m3_neg_sum", 32'(c3_osum), 32'h3C4);
    chk("m3_neg_tag", 32'(c3_otag), 32'd2);

    // Randomised traffic with bubbles and backpressure
    d_rand_on = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      logic [95:0] rv;
      int unsigned g;
      if ($urandom_range(0, 3) == 0) begin
        d_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      rv      = {$urandom(), $urandom(), $urandom()};
      d_data  = rv[79:0];
      d_neg   = 5'($urandom());
      d_tag   = 4'(i);
      d_valid = 1'b1;
      g = 0;
      @(negedge clk);
      while (!d_irdy && g < 200) begin
        @(negedge clk);
        g++;
      end
      if (!d_irdy) chk("d_in_handshake", 32'(d_irdy), 32'd1);
      qd.push_back({d_tag, model_d(d_data, d_neg)});
      @(posedge clk);
      #1;
    end
    d_valid   = 1'b0;
    d_rand_on = 1'b0;
    drain("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
